// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: shared types and helpers for the shift arbiter.
//   shift_op_t  - 2-bit op encoding presented by each requester.
//   bit_reverse - reverses the low w bits of a value. SLL reuses the shared
//                 right shifter by reversing the operand before the shift and
//                 the result after it.
package shift_arb_pkg;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

  // Widest operand bit_reverse can handle; callers widen and narrow with casts.
  localparam int SHW_MAX = 64;

  function automatic logic [SHW_MAX-1:0] bit_reverse(input logic [SHW_MAX-1:0] v,
                                                     input int w);
    logic [SHW_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < SHW_MAX; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_valid - per-requester valid
//   ptr       - requester with highest priority this cycle
//   en        - when low, no grant is issued
//   grant     - one-hot grant (all zero when en is low or nobody is valid)
// Scans upward from ptr, wrapping modulo NREQ, and grants the first valid.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin shares one shift datapath among NREQ requesters
// and holds the result in a 1-deep registered slot with valid/ready.
//   CLK, RST_N            - clock (rising edge), async active-low reset
//   REQ_VALID/REQ_READY   - per-requester handshake; READY is one-hot or zero
//   REQ_A/REQ_B/REQ_OP    - per-requester operand, shift amount, op (NBITS/NBITS/2 slices)
//   RES_VALID/RES_READY   - result slot handshake
//   RES_DATA/RES_ID       - registered result and the requester that produced it
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NBITS = 4,
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       REQ_VALID,
  output logic [NREQ-1:0]       REQ_READY,
  input  logic [NREQ*NBITS-1:0] REQ_A,
  input  logic [NREQ*NBITS-1:0] REQ_B,
  input  logic [NREQ*2-1:0]     REQ_OP,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [NBITS-1:0]      RES_DATA,
  output logic [IDW-1:0]        RES_ID
);

  logic [IDW-1:0]   ptr_p1;
  logic             vld_p1;
  logic [NBITS-1:0] data_p1;
  logic [IDW-1:0]   id_p1;

  logic             accept_en;
  logic [NREQ-1:0]  grant;
  logic             xfer;
  logic [IDW-1:0]   gidx;
  logic [NBITS-1:0] a_sel;
  logic [NBITS-1:0] b_sel;
  shift_op_t        op_sel;
  logic [NBITS-1:0] sh_in;
  logic             sh_fill;
  logic [NBITS-1:0] sh_out;
  logic [NBITS-1:0] rot;
  logic [NBITS-1:0] sh_res;

  // ---- stage p0: arbitration, operand mux, shared shift datapath ----
  assign accept_en = !vld_p1 || RES_READY;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid (REQ_VALID),
    .ptr       (ptr_p1),
    .en        (accept_en),
    .grant     (grant)
  );

  // Gated by RST_N so no requester sees an accept while reset is asserted.
  assign REQ_READY = grant & {NREQ{RST_N}};
  assign xfer      = |grant;

  always_comb begin
    gidx   = '0;
    a_sel  = '0;
    b_sel  = '0;
    op_sel = OP_SRL;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gidx   = IDW'(i);
        a_sel  = REQ_A[i*NBITS +: NBITS];
        b_sel  = REQ_B[i*NBITS +: NBITS];
        op_sel = shift_op_t'(REQ_OP[i*2 +: 2]);
      end
    end
  end

  // Single right shifter: SLL enters bit-reversed with zero fill, SRA fills
  // with the operand sign bit. Amounts >= NBITS shift everything out.
  assign sh_in   = (op_sel == OP_SLL) ? NBITS'(bit_reverse(64'(a_sel), NBITS)) : a_sel;
  assign sh_fill = (op_sel == OP_SRA) & a_sel[NBITS-1];

  always_comb begin
    int src;
    int r;
    sh_out = '0;
    rot    = '0;
    src    = 0;
    r      = int'(b_sel) % NBITS;
    for (int i = 0; i < NBITS; i++) begin
      src = i + int'(b_sel);
      if (src < NBITS) sh_out[i] = sh_in[src];
      else             sh_out[i] = sh_fill;
      rot[i] = a_sel[(i + r) % NBITS];
    end
  end

  always_comb begin
    case (op_sel)
      OP_SLL:  sh_res = NBITS'(bit_reverse(64'(sh_out), NBITS));
      OP_ROR:  sh_res = rot;
      default: sh_res = sh_out;
    endcase
  end

  // ---- stage p1: result slot and round-robin pointer ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= '0;
      ptr_p1  <= '0;
    end else begin
      if (xfer) begin
        vld_p1  <= 1'b1;
        data_p1 <= sh_res;
        id_p1   <= gidx;
        ptr_p1  <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
      end else if (RES_READY) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign RES_VALID = vld_p1;
  assign RES_DATA  = data_p1;
  assign RES_ID    = id_p1;

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one combinational shift datapath between NREQ requesters. Arbitration is round-robin. Each requester submits {A, B, OP} on a valid/ready handshake. The block selects one request per cycle, computes the shift and holds it in a 1-deep registered result slot with valid/ready backpressure. It sits between the ALU issue logic (several ports) and the shift datapath, so the shifter is time-multiplexed and never duplicated.

Parameters:
NBITS, 4, operand/result width; also the width of the shift amount B.
NREQ, 2, number of requesters; must be >= 2.
IDW, $clog2(NREQ), width of the requester id.

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
REQ_VALID  input  NREQ  per-requester request valid.
REQ_READY  output  NREQ  per-requester accept; at most one bit high.
REQ_A  input  NREQ*NBITS  operands; requester i uses slice [i*NBITS +: NBITS].
REQ_B  input  NREQ*NBITS  shift amounts, unsigned, same slicing.
REQ_OP  input  NREQ*2  op per requester: 00 SRL, 01 SRA, 10 SLL, 11 ROR.
RES_VALID  output  1  result slot full.
RES_READY  input  1  consumer accepts the result.
RES_DATA  output  NBITS  registered shift result.
RES_ID  output  IDW  index of the requester that produced RES_DATA.

Behaviour:
- Reset (RST_N=0, asynchronous): RES_VALID=0, RES_DATA=0, RES_ID=0, round-robin pointer=0 (requester 0 highest priority). REQ_READY=0 while in reset.
- Slot states:
  - EMPTY: RES_VALID=0.
  - FULL: RES_VALID=1.
  - EMPTY->FULL on accept.
  - FULL->EMPTY on RES_READY with no new accept.
  - FULL->FULL on drain and accept in the same cycle.
- accept_en = !RES_VALID || RES_READY. Full throughput: one result per cycle.
- Grant: when accept_en=1, the first i with REQ_VALID[i]=1, scanning from the pointer upward and wrapping modulo NREQ. REQ_READY = one-hot grant & accept_en. REQ_READY depends combinationally on REQ_VALID and RES_READY. Requesters must not make REQ_VALID depend on REQ_READY.
- Handshake: a transfer occurs when REQ_VALID[i]&&REQ_READY[i]. A requester holds VALID and payload stable until accepted. A non-granted requester keeps waiting; there is no drop.
- On transfer at edge k:
  - RES_DATA and RES_ID load; RES_VALID=1 after edge k (latency 1).
  - Pointer becomes (granted+1) mod NREQ.
  - The pointer is unchanged when nothing transfers.
- Result stability: while RES_VALID=1 and RES_READY=0, RES_DATA and RES_ID hold and all REQ_READY=0.
- Arithmetic, with s = B as unsigned:
  - SRL: zero-fill right shift. Result 0 if s >= NBITS.
  - SRA: sign-fill right shift with A[NBITS-1]. Result all sign bits if s >= NBITS.
  - SLL: computed as bit-reverse(SRL(bit-reverse(A), s)). Result 0 if s >= NBITS.
  - ROR: rotate right by s mod NBITS.
- All right shifts use a single shared right-shifter instance fed through the selected-request mux. The sign-fill input = (OP==SRA) & A[MSB].
- Simultaneous events: drain and accept in one cycle → new data is loaded and RES_VALID stays 1. Reset mid-operation → pending result lost, requesters must re-present.

Decomposition:
- Package shift_arb_pkg:
  - typedef enum logic [1:0] shift_op_t {OP_SRL, OP_SRA, OP_SLL, OP_ROR}.
  - function bit_reverse.
- Sub-module rr_pick #(NREQ):
  - inputs REQ_VALID, pointer, enable.
  - output one-hot grant, purely combinational.
- The top level holds the pointer register, the result slot, the operand mux and the shift datapath.

Test Plan:
(NBITS=4, NREQ=2, RES_READY=1 unless stated.)
- Op sweep on requester 0:
  - SRL A=1010 B=1 → 0101.
  - SRA A=1010 B=1 → 1101.
  - SLL A=0011 B=2 → 1100.
  - ROR A=0001 B=1 → 1000.
  - Each result appears one cycle after accept, RES_ID=0.
- Over-range amounts, A=1000 B=5:
  - SRL → 0000.
  - SRA → 1111.
  - SLL → 0000.
  - ROR → 0100.
- Both REQ_VALID held high for 6 cycles → grants 0,1,0,1,0,1. RES_ID alternates and one result is produced every cycle.
- Backpressure:
  - Stimulus: fill the slot, hold RES_READY=0 for 3 cycles, then raise it for 1 cycle.
  - During the stall: RES_VALID=1, RES_DATA/RES_ID stable, REQ_READY=00.
  - On release: drain plus a new accept in the same cycle.
- Only requester 1 valid, starting from pointer=0 → requester 1 is granted every cycle and RES_ID=1 throughout.
- RST_N pulled low while RES_VALID=1 and the pointer is 1 → RES_VALID=0 immediately (no clock edge). After release, with both requesters valid, requester 0 is granted first.
